// File: rtl/mac_ctrl_seq_pkg.sv
// -----------------------------------------------------------------------------
// mac_ctrl_seq_pkg
// Shared types and constants for the MAC control sequencer:
//   - seq_state_e : sequencer state encoding (also exported as seq_state)
//   - CFG_*       : bit positions inside the 4-bit cfg vector
//   - CFG_RESET_VAL : config applied out of reset (jumbo on, CRC gen/check on)
//   - ctl_t / state_ctl() : Moore decode of the MAC/queue control outputs
// -----------------------------------------------------------------------------
package mac_ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET    = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_OFF      = 3'd2,
        ST_RUN      = 3'd3,
        ST_DRAIN_RX = 3'd4,
        ST_DRAIN_TX = 3'd5
    } seq_state_e;

    // cfg vector: {enable_jumbo_tx, enable_jumbo_rx, disable_crc_gen, disable_crc_check}
    localparam int CFG_JUMBO_TX = 3;
    localparam int CFG_JUMBO_RX = 2;
    localparam int CFG_CRC_GEN  = 1;
    localparam int CFG_CRC_CHK  = 0;

    localparam logic [3:0] CFG_RESET_VAL = 4'b1100;

    typedef struct packed {
        logic reset_mac;
        logic rx_mac_en;
        logic tx_mac_en;
        logic rx_queue_en;
        logic tx_queue_en;
    } ctl_t;

    localparam ctl_t CTL_RESET = '{reset_mac: 1'b1, default: 1'b0};

    // Control outputs as a pure function of state. The receiver side is shut
    // first (DRAIN_RX) so in-flight rx frames finish; then queue intake stops
    // while the transmitter empties the tx queue (DRAIN_TX).
    function automatic ctl_t state_ctl(input seq_state_e s);
        ctl_t c;
        c = '0;
        case (s)
            ST_RESET:    c.reset_mac = 1'b1;
            ST_RUN:      c = '{reset_mac: 1'b0, default: 1'b1};
            ST_DRAIN_RX: begin
                c.tx_mac_en   = 1'b1;
                c.rx_queue_en = 1'b1;
                c.tx_queue_en = 1'b1;
            end
            ST_DRAIN_TX: c.tx_mac_en = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mac_ctrl_seq.sv
// -----------------------------------------------------------------------------
// mac_ctrl_seq
// Owns the control inputs of one MAC group's MAC and rx/tx queues. Config
// changes and disables go through a safe order: stop MAC rx, drain rx, stop
// queue intake, drain tx, pulse MAC reset, apply config, re-enable.
//
// Parameters:
//   RESET_CYCLES  - cycles reset_MAC is held per reset pulse (>=2)
//   DRAIN_TIMEOUT - max cycles across both drain states before forcing on (>=2)
// Optional build macro:
//   MAC_CTRL_SEQ_TIMEOUT_EN - enables the drain timeout and cfg_timeout; when
//                             undefined, drains wait for busy=0 indefinitely.
// Ports:
//   clk, reset_n        - clock, async active-low reset
//   mac_en_req          - register-level enable for MAC and queues
//   cfg_req / cfg_in    - level request + config to apply; cfg_ack pulses once
//   cfg_timeout         - pulses when a drain is abandoned
//   rx_busy / tx_busy   - queue activity (already in clk domain)
//   reset_MAC, rx/tx_mac_en, rx/tx_queue_en - registered MAC/queue controls
//   cfg_out             - applied config
//   seq_state           - current state for register readback
// -----------------------------------------------------------------------------
module mac_ctrl_seq #(
    parameter int RESET_CYCLES  = 16,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mac_en_req,
    input  logic       cfg_req,
    input  logic [3:0] cfg_in,
    output logic       cfg_ack,
    output logic       cfg_timeout,
    input  logic       rx_busy,
    input  logic       tx_busy,
    output logic       reset_MAC,
    output logic       rx_mac_en,
    output logic       tx_mac_en,
    output logic       rx_queue_en,
    output logic       tx_queue_en,
    output logic [3:0] cfg_out,
    output logic [2:0] seq_state
);
    import mac_ctrl_seq_pkg::*;

    localparam int CNT_MAX = (RESET_CYCLES > DRAIN_TIMEOUT) ? RESET_CYCLES : DRAIN_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] RST_LAST    = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(1);
`ifdef MAC_CTRL_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST    = CW'(DRAIN_TIMEOUT - 1);
`endif

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [3:0]    cfg_out_q, cfg_out_d;
    logic          ack_q, ack_d;
    logic          tmo_q, tmo_d;
    ctl_t          ctl_q, ctl_d;

    logic          req;
    seq_state_e    drain_exit;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        cfg_out_d  = cfg_out_q;
        ack_d      = 1'b0;
        tmo_d      = 1'b0;
        // The requester sees cfg_ack one cycle late, so cfg_req is ignored
        // during the ack cycle; still high the cycle after = new request.
        req        = cfg_req & ~ack_q;
        drain_exit = pend_q ? ST_RESET : ST_OFF;

        case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = mac_en_req ? ST_RUN : ST_OFF;
                    if (pend_q) begin
                        ack_d  = 1'b1;
                        pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_OFF: begin
                cnt_d = '0;
                if (req) begin
                    pend_d  = 1'b1;
                    state_d = ST_RESET;
                end else if (mac_en_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (req || !mac_en_req) begin
                    state_d = ST_DRAIN_RX;
                    if (req) pend_d = 1'b1;
                end
            end
            ST_DRAIN_RX: begin
`ifdef MAC_CTRL_SEQ_TIMEOUT_EN
                // Timeout skips DRAIN_TX entirely: the tx drain budget is shared.
                if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = drain_exit;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!rx_busy) state_d = ST_DRAIN_TX;
                end
`else
                cnt_d = '0;
                if (!rx_busy) state_d = ST_DRAIN_TX;
`endif
            end
            ST_DRAIN_TX: begin
`ifdef MAC_CTRL_SEQ_TIMEOUT_EN
                if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = drain_exit;
                    cnt_d   = '0;
                end else if (!tx_busy) begin
                    state_d = drain_exit;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`else
                cnt_d = '0;
                if (!tx_busy) state_d = drain_exit;
`endif
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase

        // New config lands on the edge that enters RESET, so the MAC comes out
        // of its reset pulse already seeing it.
        if (pend_d && state_d == ST_RESET && state_q != ST_RESET)
            cfg_out_d = cfg_in;

        ctl_d = state_ctl(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            cfg_out_q <= CFG_RESET_VAL;
            ack_q     <= 1'b0;
            tmo_q     <= 1'b0;
            ctl_q     <= CTL_RESET;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            cfg_out_q <= cfg_out_d;
            ack_q     <= ack_d;
            tmo_q     <= tmo_d;
            ctl_q     <= ctl_d;
        end
    end

    assign cfg_ack     = ack_q;
    assign cfg_timeout = tmo_q;
    assign reset_MAC   = ctl_q.reset_mac;
    assign rx_mac_en   = ctl_q.rx_mac_en;
    assign tx_mac_en   = ctl_q.tx_mac_en;
    assign rx_queue_en = ctl_q.rx_queue_en;
    assign tx_queue_en = ctl_q.tx_queue_en;
    assign cfg_out     = cfg_out_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_mac_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_ctrl_seq
// Directed bench for mac_ctrl_seq with RESET_CYCLES=16, DRAIN_TIMEOUT=64.
// Inputs are driven and outputs sampled on the falling clock edge; "c" in the
// loops is the number of rising edges since the scenario started.
// -----------------------------------------------------------------------------
module tb_mac_ctrl_seq;

    localparam int RC = 16;
    localparam int DT = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mac_en_req = 1'b1;
    logic       cfg_req = 1'b0;
    logic [3:0] cfg_in = 4'h0;
    logic       rx_busy = 1'b0;
    logic       tx_busy = 1'b0;
    logic       cfg_ack, cfg_timeout, reset_MAC;
    logic       rx_mac_en, tx_mac_en, rx_queue_en, tx_queue_en;
    logic [3:0] cfg_out;
    logic [2:0] seq_state;
    logic [3:0] en;

    int n_cmp = 0;
    int n_bad = 0;

    assign en = {rx_mac_en, tx_mac_en, rx_queue_en, tx_queue_en};

    mac_ctrl_seq #(.RESET_CYCLES(RC), .DRAIN_TIMEOUT(DT)) dut (
        .clk(clk), .reset_n(reset_n), .mac_en_req(mac_en_req),
        .cfg_req(cfg_req), .cfg_in(cfg_in), .cfg_ack(cfg_ack),
        .cfg_timeout(cfg_timeout), .rx_busy(rx_busy), .tx_busy(tx_busy),
        .reset_MAC(reset_MAC), .rx_mac_en(rx_mac_en), .tx_mac_en(tx_mac_en),
        .rx_queue_en(rx_queue_en), .tx_queue_en(tx_queue_en),
        .cfg_out(cfg_out), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rstmac"}, 32'(reset_MAC), 32'd1);
        chk({tag, "_en"}, 32'(en), 32'h0);
        chk({tag, "_cfg"}, 32'(cfg_out), 32'hC);
        chk({tag, "_state"}, 32'(seq_state), 32'd0);
        chk({tag, "_ack"}, 32'(cfg_ack), 32'd0);
        chk({tag, "_tmo"}, 32'(cfg_timeout), 32'd0);
    endtask

    initial begin
        int es;

        // ---- reset values, then power-up with mac_en_req=1
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            chk($sformatf("pwr_rstmac_%0d", k), 32'(reset_MAC), 32'(k <= RC - 1));
            chk($sformatf("pwr_en_%0d", k), 32'(en), (k >= RC + 2) ? 32'hF : 32'h0);
            es = (k <= RC - 1) ? 0 : (k <= RC + 1) ? 1 : 3;
            chk($sformatf("pwr_state_%0d", k), 32'(seq_state), 32'(es));
            chk($sformatf("pwr_ack_%0d", k), 32'(cfg_ack), 32'd0);
        end
        chk("pwr_cfg", 32'(cfg_out), 32'hC);

        // ---- RUN: cfg change to 0011, rx busy 5 edges then tx busy 3 more
        cfg_in = 4'b0011;
        for (int c = 1; c <= 28; c++) begin
            cfg_req = (c <= 27);
            rx_busy = (c <= 5);
            tx_busy = (c >= 6 && c <= 8);
            @(negedge clk);
            es = (c <= 5) ? 4 : (c <= 8) ? 5 : (c <= 24) ? 0 : (c <= 26) ? 1 : 3;
            chk($sformatf("cfg_state_%0d", c), 32'(seq_state), 32'(es));
            chk($sformatf("cfg_ack_%0d", c), 32'(cfg_ack), 32'(c == 27));
            if (c == 1) chk("cfg_en_drx", 32'(en), 32'h7);
            if (c == 6) chk("cfg_en_dtx", 32'(en), 32'h4);
            if (c == 8) chk("cfg_cfg_old", 32'(cfg_out), 32'hC);
            if (c == 9) begin
                chk("cfg_rstmac", 32'(reset_MAC), 32'd1);
                chk("cfg_cfg_new", 32'(cfg_out), 32'h3);
            end
            if (c == 27) chk("cfg_en_run", 32'(en), 32'hF);
        end

        // ---- RUN: mac_en_req drops with idle queues
        mac_en_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            es = (c == 1) ? 4 : (c == 2) ? 5 : 2;
            chk($sformatf("dis_state_%0d", c), 32'(seq_state), 32'(es));
            chk($sformatf("dis_rstmac_%0d", c), 32'(reset_MAC), 32'd0);
            chk($sformatf("dis_ack_%0d", c), 32'(cfg_ack), 32'd0);
        end
        chk("dis_en_off", 32'(en), 32'h0);
        chk("dis_cfg", 32'(cfg_out), 32'h3);

        // ---- stuck rx_busy with a pending config
        mac_en_req = 1'b1;
        @(negedge clk);
        chk("stk_run", 32'(seq_state), 32'd3);
        cfg_in = 4'b1010;
`ifdef MAC_CTRL_SEQ_TIMEOUT_EN
        for (int c = 1; c <= 84; c++) begin
            rx_busy = 1'b1;
            cfg_req = (c <= 83);
            @(negedge clk);
            es = (c <= DT) ? 4 : (c <= DT + RC) ? 0 : (c <= DT + RC + 2) ? 1 : 3;
            chk($sformatf("tmo_state_%0d", c), 32'(seq_state), 32'(es));
            chk($sformatf("tmo_pulse_%0d", c), 32'(cfg_timeout), 32'(c == DT + 1));
            chk($sformatf("tmo_ack_%0d", c), 32'(cfg_ack), 32'(c == DT + RC + 3));
            if (c == DT + 1) chk("tmo_cfg", 32'(cfg_out), 32'hA);
        end
`else
        for (int c = 1; c <= 121; c++) begin
            rx_busy = (c <= 100);
            cfg_req = (c <= 120);
            @(negedge clk);
            es = (c <= 100) ? 4 : (c == 101) ? 5 : (c <= 117) ? 0 : (c <= 119) ? 1 : 3;
            chk($sformatf("stk_state_%0d", c), 32'(seq_state), 32'(es));
            chk($sformatf("stk_tmo_%0d", c), 32'(cfg_timeout), 32'd0);
            chk($sformatf("stk_ack_%0d", c), 32'(cfg_ack), 32'(c == 120));
            if (c == 102) chk("stk_cfg", 32'(cfg_out), 32'hA);
        end
`endif
        rx_busy = 1'b0;

        // ---- OFF: cfg 1111 goes straight to RESET
        mac_en_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("off_state", 32'(seq_state), 32'd2);
        cfg_in = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            cfg_req = (c <= RC + 3);
            @(negedge clk);
            es = (c <= RC) ? 0 : (c <= RC + 2) ? 1 : 2;
            chk($sformatf("ofc_state_%0d", c), 32'(seq_state), 32'(es));
            chk($sformatf("ofc_ack_%0d", c), 32'(cfg_ack), 32'(c == RC + 3));
            if (c == 1) begin
                chk("ofc_rstmac", 32'(reset_MAC), 32'd1);
                chk("ofc_cfg", 32'(cfg_out), 32'hF);
            end
        end
        chk("ofc_en_off", 32'(en), 32'h0);

        // ---- async reset in DRAIN_TX with pend=1, then held cfg_req re-serviced
        mac_en_req = 1'b1;
        @(negedge clk);
        cfg_in  = 4'b0101;
        cfg_req = 1'b1;
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("ar_dtx", 32'(seq_state), 32'd5);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("ar");
        @(negedge clk);
        tx_busy = 1'b0;
        reset_n = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            @(negedge clk);
            es = (c <= RC - 1) ? 0 : (c <= RC + 1) ? 1 : (c == 18) ? 3 : (c == 19) ? 4 :
                 (c == 20) ? 5 : (c <= 36) ? 0 : (c <= 38) ? 1 : 3;
            chk($sformatf("ar_state_%0d", c), 32'(seq_state), 32'(es));
            chk($sformatf("ar_ack_%0d", c), 32'(cfg_ack), 32'(c == 39));
            if (c == 18) chk("ar_cfg_rst", 32'(cfg_out), 32'hC);
            if (c == 39) begin
                chk("ar_cfg_new", 32'(cfg_out), 32'h5);
                cfg_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("ar_final_state", 32'(seq_state), 32'd3);
        chk("ar_final_ack", 32'(cfg_ack), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
